// File: rtl/csel_mp_add_seq.sv
// rtl/csel_mp_add_seq.sv - multi-precision add/subtract sequencer driving a CHUNK-bit carry-select adder
// Walks WIDTH-bit operands LSB chunk first, chaining each chunk's carry-out into the next.
module csel_mp_add_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic [CHUNK-1:0] add_a,
  output logic [CHUNK-1:0] add_b,
  output logic             add_cin,
  input  logic [CHUNK-1:0] add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa, opb, sum_q;
  logic             cin0, carry_q;
  logic [KW-1:0]    k;
  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             run, done;

  // Constant-index mux keeps the slice select free of variable part-selects.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < N; i++) begin
      if (k == KW'(i)) begin
        chunk_a = opa[i*CHUNK +: CHUNK];
        chunk_b = opb[i*CHUNK +: CHUNK];
      end
    end
  end

  assign run     = (state == RUN);
  assign done    = (state == DONE);
  assign add_a   = run ? chunk_a : '0;
  assign add_b   = run ? chunk_b : '0;
  assign add_cin = run && ((k == '0) ? cin0 : carry_q);

  assign in_ready  = (state == IDLE);
  assign out_valid = done;
  assign out_sum   = done ? sum_q : '0;
  assign out_cout  = done && carry_q;
  // opb already holds ~b for subtract, so one overflow rule covers both operations.
  assign out_ovf   = done && (opa[WIDTH-1] == opb[WIDTH-1]) && (sum_q[WIDTH-1] != opa[WIDTH-1]);
  assign out_zero  = done && ~|sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      opa     <= '0;
      opb     <= '0;
      sum_q   <= '0;
      cin0    <= 1'b0;
      carry_q <= 1'b0;
      k       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= in_a;
            opb   <= in_sub ? ~in_b : in_b;
            cin0  <= in_sub | in_cin;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) sum_q[i*CHUNK +: CHUNK] <= add_s;
          end
          carry_q <= add_cout;
          k       <= k + KW'(1);
          if (k == KW'(N - 1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csel_mp_add_seq.sv
// tb/tb_csel_mp_add_seq.sv - randomized self-checking bench for csel_mp_add_seq
`timescale 1ns/1ps
module tb_csel_mp_add_seq;

  localparam int WIDTH = 64;
  localparam int CHUNK = 16;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_cin, in_sub;
  logic [WIDTH-1:0] in_a, in_b;
  logic [CHUNK-1:0] add_a, add_b, add_s;
  logic             add_cin, add_cout;
  logic             out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [WIDTH-1:0] out_sum;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] obs_sum;
  logic             obs_cout, obs_ovf, obs_zero;
  logic [N-1:0]     obs_cins;
  logic [CHUNK-1:0] obs_b0;

  csel_mp_add_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  // Stand-in for the attached 16-bit adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{CHUNK{1'b0}}, add_cin};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                input logic sub, output logic [63:0] sum, output logic cout,
                                output logic ovf, output logic [N-1:0] cins);
    logic [63:0] bb, mask;
    logic [64:0] wide, part;
    logic        c0;
    bb = sub ? ~b : b;
    c0 = sub ? 1'b1 : cin;
    if (sub) begin
      sum  = a - b;
      cout = (a >= b);
      ovf  = (a[63] != b[63]) && (sum[63] != a[63]);
    end else begin
      wide = {1'b0, a} + {1'b0, b} + {64'd0, cin};
      sum  = wide[63:0];
      cout = wide[64];
      ovf  = (a[63] == b[63]) && (sum[63] != a[63]);
    end
    cins[0] = c0;
    for (int i = 1; i < N; i++) begin
      mask    = (64'd1 << (CHUNK * i)) - 64'd1;
      part    = ({1'b0, a & mask} + {1'b0, bb & mask} + {64'd0, c0}) >> (CHUNK * i);
      cins[i] = part[0];
    end
  endfunction

  // Entered and left just after a falling edge.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input logic sub, input int hold, input bit keep);
    logic [63:0] e_sum;
    logic        e_cout, e_ovf;
    logic [N-1:0] e_cins;
    int          n, bad;
    model(a, b, cin, sub, e_sum, e_cout, e_ovf, e_cins);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check("accept_timeout", 64'(n < 100), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    obs_b0   = add_b;
    obs_cins = '0;
    n = 0;
    while (!out_valid && n < 20) begin
      if (n < N) obs_cins[n] = add_cin;
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(N));
    obs_sum = out_sum; obs_cout = out_cout; obs_ovf = out_ovf; obs_zero = out_zero;
    check("sum", obs_sum, e_sum);
    check("cout", 64'(obs_cout), 64'(e_cout));
    check("ovf", 64'(obs_ovf), 64'(e_ovf));
    check("zero", 64'(obs_zero), 64'(e_sum == 64'd0));
    check("cin_seq", 64'(obs_cins), 64'(e_cins));
    check("busy_ready", 64'(in_ready), 64'd0);
    bad = 0;
    in_valid = keep;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (out_sum !== e_sum || !out_valid || in_ready) bad++;
    end
    if (hold > 0) check("hold_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_ready", 64'(in_ready), 64'd1);
    check("post_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_zero", 64'(out_zero), 64'd0);
    check("rst_out_sum", out_sum, 64'd0);
    check("rst_add", {add_a, add_b, 31'd0, add_cin}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0);
    check("wrap_sum", obs_sum, 64'd0);
    check("wrap_zero", 64'(obs_zero), 64'd1);
    check("wrap_cins", 64'(obs_cins), 64'b1110);

    do_op(64'd5, 64'd7, 1'b0, 1'b1, 0, 1'b0);
    check("sub_sum", obs_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_cout", 64'(obs_cout), 64'd0);
    check("sub_b0", 64'(obs_b0), 64'hFFF8);
    check("sub_cin0", 64'(obs_cins[0]), 64'd1);

    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0);
    check("ovf_sum", obs_sum, 64'h8000_0000_0000_0000);
    check("ovf_flag", 64'(obs_ovf), 64'd1);

    do_op(64'h0000_FFFF_0000_FFFF, 64'd0, 1'b1, 1'b0, 0, 1'b0);
    check("chain_sum", obs_sum, 64'h0000_FFFF_0001_0000);
    check("chain_cins", 64'(obs_cins), 64'b0011);

    // Backpressure: the repeated request waits through DONE, then goes straight in.
    do_op(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 10, 1'b1);
    do_op(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 0, 1'b0);

    // Reset while chunk 2 is on the adder.
    in_a = 64'hDEAD_BEEF_0000_1111; in_b = 64'h1; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_add", {add_a, add_b, 31'd0, add_cin}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("no_stray_valid", 64'(cnt), 64'd0);
    check("rst_idle_ready", 64'(in_ready), 64'd1);
    do_op(64'h1234, 64'h1, 1'b0, 1'b0, 0, 1'b0);
    check("after_rst_sum", obs_sum, 64'h1235);

    for (int t = 0; t < 30; t++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: ra = ~64'd0;
        1: rb = ra;
        2: rb = {48'd0, rb[15:0]};
        default: ;
      endcase
      do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
